pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the single-issue RISC-V datapath.
- Drives pc_out into the datapath's 32-bit adders (PC+4, PC+imm) and the instruction memory. Consumes those adder results to choose the next PC.
- Runs a req/ack handshake with instruction memory and holds each fetched instruction until decode accepts it.

---
 rtl/pc_fetch_unit_pkg.sv | 18 +
 rtl/pc_fetch_unit_next_pc_mux.sv | 31 +++
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC / instruction-fetch sequencer.
package pc_fetch_unit_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4  = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JALR   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Next-PC select with alignment mask; flags targets whose low bits were non-zero.
module pc_fetch_unit_next_pc_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_pc_plus4,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_jalr_target,
  output logic [31:0] o_next_pc,
  output logic        o_misalign
);

  logic [31:0] w_jalr_even;
  logic [31:0] w_sel;

  // JALR semantics drop bit 0 before the target is judged for alignment.
  assign w_jalr_even = {i_jalr_target[31:1], 1'b0};

  always_comb begin
    w_sel = i_pc_plus4;
    case (i_pc_src)
      PC_SRC_BRANCH: w_sel = i_br_target;
      PC_SRC_JALR:   w_sel = w_jalr_even;
      default:       w_sel = i_pc_plus4;
    endcase
  end

  assign o_next_pc  = {w_sel[31:2], 2'b00};
  assign o_misalign = |w_sel[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: BOOT -> REQ (wait imem_ack) -> HOLD (wait decode).
// Handshakes: imem_req stays high with a stable address until imem_ack; decode takes the held
// instruction when id_ready=1 and stall=0 in HOLD. Ack outside REQ is ignored.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pc_fetch_unit_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_target,
  input  logic [1:0]  pc_src,
  input  logic        stall,
  input  logic        id_ready,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign,
  output logic [31:0] retire_cnt,
  output logic [1:0]  state_dbg
);
  import pc_fetch_unit_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_pc;
  logic [31:0]  r_retire_cnt;
  logic         r_inst_valid;
  logic         r_misalign;
  logic         w_capture;
  logic         w_advance;
  logic [31:0]  w_next_pc;
  logic         w_target_misalign;

  pc_fetch_unit_next_pc_mux u_next_pc_mux (
    .i_pc_src      (pc_src),
    .i_pc_plus4    (pc_plus4),
    .i_br_target   (br_target),
    .i_jalr_target (jalr_target),
    .o_next_pc     (w_next_pc),
    .o_misalign    (w_target_misalign)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = REQ;
      REQ: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (id_ready && !stall) begin
          w_advance   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_INST;
      r_inst_pc    <= 32'h0;
      r_inst_valid <= 1'b0;
      r_retire_cnt <= 32'h0;
      r_misalign   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Pulse lasts exactly the cycle after the advance that used the bad target.
      r_misalign <= w_advance & w_target_misalign;
      if (w_capture) begin
        r_inst       <= imem_rdata;
        r_inst_pc    <= r_pc;
        r_inst_valid <= 1'b1;
      end else if (w_advance) begin
        r_pc         <= w_next_pc;
        r_inst       <= NOP_INST;
        r_inst_valid <= 1'b0;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  assign pc_out     = r_pc;
  assign imem_req   = (r_state == REQ);
  assign imem_addr  = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign misalign   = r_misalign;
  assign retire_cnt = r_retire_cnt;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios for pc_fetch_unit with RESET_PC=0x1000; expected values are hand-computed.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jalr_target;
  logic [1:0]  pc_src;
  logic        stall;
  logic        id_ready;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign;
  logic [31:0] retire_cnt;
  logic [1:0]  state_dbg;

  int n_checks;
  int n_fail;

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;

  pc_fetch_unit #(
    .RESET_PC (32'h0000_1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_plus4    (pc_plus4),
    .br_target   (br_target),
    .jalr_target (jalr_target),
    .pc_src      (pc_src),
    .stall       (stall),
    .id_ready    (id_ready),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .misalign    (misalign),
    .retire_cnt  (retire_cnt),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_plus4 = 32'h0; br_target = 32'h0; jalr_target = 32'h0; pc_src = 2'b00;
    stall = 1'b0; id_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++; if (pc_out !== 32'h0000_1000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0000_1000); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h want 00000013", inst); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    n_checks++; if (retire_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_retire: got %h want 0", retire_cnt); end
    n_checks++; if (state_dbg !== S_BOOT) begin n_fail++; $display("FAIL reset_state: got %b want %b", state_dbg, S_BOOT); end
  endtask

  task automatic test_zero_wait_fetch();
    // Memory answers in the same cycle it sees the request; BOOT must ignore the early ack.
    imem_ack = 1'b1; imem_rdata = 32'h0010_0093;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req_rise: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL zw_addr: got %h want 00001000", imem_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL zw_boot_ack_ignored: got %b want 0", inst_valid); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid: got %b want 1", inst_valid); end
    n_checks++; if (inst !== 32'h0010_0093) begin n_fail++; $display("FAIL zw_inst: got %h want 00100093", inst); end
    n_checks++; if (inst_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL zw_inst_pc: got %h want 00001000", inst_pc); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL zw_req_drop: got %b want 0", imem_req); end
    n_checks++; if (state_dbg !== S_HOLD) begin n_fail++; $display("FAIL zw_state: got %b want %b", state_dbg, S_HOLD); end
    imem_ack = 1'b0;
  endtask

  task automatic test_delayed_ack();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL dly_req[%0d]: got %b want 1", i, imem_req); end
      n_checks++; if (imem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL dly_addr[%0d]: got %h want 00001000", i, imem_addr); end
      n_checks++; if (pc_out !== 32'h0000_1000) begin n_fail++; $display("FAIL dly_pc[%0d]: got %h want 00001000", i, pc_out); end
      stall = (i % 2 == 0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0020_0113;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL dly_valid: got %b want 1", inst_valid); end
    n_checks++; if (inst !== 32'h0020_0113) begin n_fail++; $display("FAIL dly_inst: got %h want 00200113", inst); end
    n_checks++; if (inst_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL dly_inst_pc: got %h want 00001000", inst_pc); end
  endtask

  task automatic test_hold_stall();
    id_ready = 1'b1; stall = 1'b1; pc_src = 2'b00; pc_plus4 = 32'h0000_1004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (pc_out !== 32'h0000_1000) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 00001000", i, pc_out); end
      n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL stall_retire[%0d]: got %0d want 0", i, retire_cnt); end
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, inst_valid); end
    end
    stall = 1'b0;
    @(negedge clk);
    id_ready = 1'b0;
    n_checks++; if (pc_out !== 32'h0000_1004) begin n_fail++; $display("FAIL adv_pc: got %h want 00001004", pc_out); end
    n_checks++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL adv_retire: got %0d want 1", retire_cnt); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL adv_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL adv_nop: got %h want 00000013", inst); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL adv_req: got %b want 1", imem_req); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL adv_misalign: got %b want 0", misalign); end
    @(negedge clk);
    n_checks++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL adv_no_double: got %0d want 1", retire_cnt); end
    n_checks++; if (imem_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL adv_addr: got %h want 00001004", imem_addr); end
  endtask

  task automatic test_branch_jalr();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0063;
    @(negedge clk);
    imem_ack = 1'b0;
    // pc_src moves while decode is not ready: PC must not follow it.
    pc_src = 2'b01; br_target = 32'h0000_2002; pc_plus4 = 32'h0000_1008;
    @(negedge clk);
    n_checks++; if (pc_out !== 32'h0000_1004) begin n_fail++; $display("FAIL nonadv_pc: got %h want 00001004", pc_out); end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0; pc_src = 2'b00;
    n_checks++; if (pc_out !== 32'h0000_2000) begin n_fail++; $display("FAIL br_pc: got %h want 00002000", pc_out); end
    n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL br_misalign: got %b want 1", misalign); end
    n_checks++; if (retire_cnt !== 32'd2) begin n_fail++; $display("FAIL br_retire: got %0d want 2", retire_cnt); end
    @(negedge clk);
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL br_pulse_end: got %b want 0", misalign); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0067;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (inst_pc !== 32'h0000_2000) begin n_fail++; $display("FAIL br_inst_pc: got %h want 00002000", inst_pc); end
    id_ready = 1'b1; pc_src = 2'b10; jalr_target = 32'h0000_3001; br_target = 32'h0000_2222; pc_plus4 = 32'h0000_2004;
    @(negedge clk);
    id_ready = 1'b0; pc_src = 2'b00;
    n_checks++; if (pc_out !== 32'h0000_3000) begin n_fail++; $display("FAIL jalr_pc: got %h want 00003000", pc_out); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL jalr_misalign: got %b want 0", misalign); end
    n_checks++; if (retire_cnt !== 32'd3) begin n_fail++; $display("FAIL jalr_retire: got %0d want 3", retire_cnt); end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    imem_ack = 1'b0;
    id_ready = 1'b1; pc_src = 2'b01; br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    id_ready = 1'b0;
    n_checks++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup_pc: got %h want fffffffc", pc_out); end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    // Encoding 11 must behave as plus4 even with a different branch target present.
    id_ready = 1'b1; pc_src = 2'b11; pc_plus4 = 32'h0000_0000; br_target = 32'h0000_5000;
    @(negedge clk);
    id_ready = 1'b0; pc_src = 2'b00;
    n_checks++; if (pc_out !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc: got %h want 00000000", pc_out); end
    n_checks++; if (imem_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL wrap_misalign: got %b want 0", misalign); end
    n_checks++; if (retire_cnt !== 32'd5) begin n_fail++; $display("FAIL wrap_retire: got %0d want 5", retire_cnt); end
  endtask

  task automatic test_reset_mid_req();
    // DUT is in REQ with no ack; reset abandons the request immediately.
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %b want 0", imem_req); end
    n_checks++; if (pc_out !== 32'h0000_1000) begin n_fail++; $display("FAIL rmid_pc: got %h want 00001000", pc_out); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL rmid_retire: got %0d want 0", retire_cnt); end
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack_valid: got %b want 0", inst_valid); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL late_ack_req: got %b want 1", imem_req); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack_still: got %b want 0", inst_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h0030_0193;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b want 1", inst_valid); end
    n_checks++; if (inst !== 32'h0030_0193) begin n_fail++; $display("FAIL clean_inst: got %h want 00300193", inst); end
    n_checks++; if (inst_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL clean_inst_pc: got %h want 00001000", inst_pc); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero_wait_fetch();
    test_delayed_ack();
    test_hold_stall();
    test_branch_jalr();
    test_wrap();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
